// File: rtl/game_turn_controller.sv
// Two-player turn sequencer for a battleship-style game: ship placement, alternating
// fire turns with bad-target hold, hit-settle delay, and win/lose display.
module game_turn_controller #(
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       BTN1A,
  input  logic       BTN3A,
  input  logic       BTN1B,
  input  logic       BTN3B,
  input  logic       OKA,
  input  logic       OKB,
  input  logic       LivA,
  input  logic       LivB,
  output logic       ST,
  output logic       LDR2A,
  output logic       LDR2B,
  output logic       game_clr,
  output logic [2:0] DispA,
  output logic [2:0] DispB,
  output logic       turn
);

  localparam int unsigned CNT_W = 27;
  localparam int unsigned DISP_W = 3;

  localparam logic [DISP_W-1:0] W_BLANK = 3'd0;
  localparam logic [DISP_W-1:0] W_PLAC  = 3'd1;
  localparam logic [DISP_W-1:0] W_WAIT  = 3'd2;
  localparam logic [DISP_W-1:0] W_FIRE  = 3'd3;
  localparam logic [DISP_W-1:0] W_BAD   = 3'd4;
  localparam logic [DISP_W-1:0] W_WIN   = 3'd5;
  localparam logic [DISP_W-1:0] W_LOSE  = 3'd6;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(1);

  typedef enum logic [3:0] {
    PLACE_A, PLACE_B, TURN_A, BAD_A, CHECK_A,
    TURN_B, BAD_B, CHECK_B, WIN_A, WIN_B
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_sat;
  logic               btn1a_q, btn3a_q, btn1b_q, btn3b_q;
  logic               p1a, p3a, p1b, p3b;
  logic               st_d, ldr2a_d, ldr2b_d, game_clr_d, turn_d;
  logic [DISP_W-1:0]  dispa_d, dispb_d;

  // Rising-edge press detection against last cycle's button levels
  assign p1a = BTN1A & ~btn1a_q;
  assign p3a = BTN3A & ~btn3a_q;
  assign p1b = BTN1B & ~btn1b_q;
  assign p3b = BTN3B & ~btn3b_q;

  assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, strobes and hold counter
  always_comb begin
    state_d    = state_q;
    ldr2a_d    = 1'b0;
    ldr2b_d    = 1'b0;
    game_clr_d = 1'b0;
    if (p3a || p3b) begin
      state_d    = PLACE_A;
      game_clr_d = 1'b1;
    end else begin
      case (state_q)
        PLACE_A: if (p1a) state_d = PLACE_B;
        PLACE_B: if (p1b) state_d = TURN_A;
        TURN_A: begin
          if (p1a) begin
            if (OKB) begin
              state_d = CHECK_A;
              ldr2a_d = 1'b1;
            end else begin
              state_d = BAD_A;
            end
          end
        end
        BAD_A:   if (cnt_q == HOLD_LAST) state_d = TURN_A;
        CHECK_A: if (cnt_q == SETTLE_LAST) state_d = LivB ? TURN_B : WIN_A;
        TURN_B: begin
          if (p1b) begin
            if (OKA) begin
              state_d = CHECK_B;
              ldr2b_d = 1'b1;
            end else begin
              state_d = BAD_B;
            end
          end
        end
        BAD_B:   if (cnt_q == HOLD_LAST) state_d = TURN_B;
        CHECK_B: if (cnt_q == SETTLE_LAST) state_d = LivA ? TURN_A : WIN_B;
        default: state_d = state_q;
      endcase
    end

    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == BAD_A || state_q == BAD_B || state_q == CHECK_A || state_q == CHECK_B)) begin
      cnt_d = cnt_sat;
    end
  end

  // Display/mode decode of the state being entered, so outputs register with it
  always_comb begin
    st_d    = 1'b1;
    turn_d  = 1'b0;
    dispa_d = W_BLANK;
    dispb_d = W_BLANK;
    case (state_d)
      PLACE_A: begin st_d = 1'b0; dispa_d = W_PLAC; dispb_d = W_WAIT; end
      PLACE_B: begin st_d = 1'b0; dispa_d = W_WAIT; dispb_d = W_PLAC; end
      TURN_A:  begin dispa_d = W_FIRE; dispb_d = W_WAIT; end
      BAD_A:   begin dispa_d = W_BAD;  dispb_d = W_WAIT; end
      CHECK_A: begin dispa_d = W_FIRE; dispb_d = W_WAIT; end
      TURN_B:  begin turn_d = 1'b1; dispa_d = W_WAIT; dispb_d = W_FIRE; end
      BAD_B:   begin turn_d = 1'b1; dispa_d = W_WAIT; dispb_d = W_BAD;  end
      CHECK_B: begin turn_d = 1'b1; dispa_d = W_WAIT; dispb_d = W_FIRE; end
      WIN_A:   begin dispa_d = W_WIN;  dispb_d = W_LOSE; end
      WIN_B:   begin dispa_d = W_LOSE; dispb_d = W_WIN;  end
      default: begin dispa_d = W_BLANK; dispb_d = W_BLANK; end
    endcase
  end

  always_ff @(posedge clk) begin
    btn1a_q <= BTN1A;
    btn3a_q <= BTN3A;
    btn1b_q <= BTN1B;
    btn3b_q <= BTN3B;
    if (!clr) begin
      state_q  <= PLACE_A;
      cnt_q    <= '0;
      ST       <= 1'b0;
      LDR2A    <= 1'b0;
      LDR2B    <= 1'b0;
      game_clr <= 1'b1;
      DispA    <= W_PLAC;
      DispB    <= W_WAIT;
      turn     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ST       <= st_d;
      LDR2A    <= ldr2a_d;
      LDR2B    <= ldr2b_d;
      game_clr <= game_clr_d;
      DispA    <= dispa_d;
      DispB    <= dispb_d;
      turn     <= turn_d;
    end
  end

endmodule
